// File: rtl/issue_scoreboard_pkg.sv
// Shared widths, types and helpers for the issue scoreboard and its write-port arbiter.
// The macro guards let a project-wide defines file take precedence when it is compiled first.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef SB_LSU_CNT_W
`define SB_LSU_CNT_W 3
`endif

package issue_scoreboard_pkg;

  localparam int XLEN      = `XLEN;
  localparam int REG_IDX_W = `REG_IDX_WIDTH;
  localparam int LSU_CNT_W = `SB_LSU_CNT_W;
  localparam int NREGS_MAX = 2 ** REG_IDX_W;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_LSU  = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rs1_idx;
    logic [REG_IDX_W-1:0] rs2_idx;
    logic [REG_IDX_W-1:0] rd_idx;
    logic                 rd_en;
    logic                 lsu;
  } iss_slot_t;

  // One-hot register mask; x0 never produces a bit, so it can never be marked busy.
  function automatic logic [NREGS_MAX-1:0] idx_decode(input logic [REG_IDX_W-1:0] idx,
                                                      input logic                 en);
    logic [NREGS_MAX-1:0] vec;
    vec = '0;
    if (en && (idx != '0)) begin
      vec[idx] = 1'b1;
    end else begin
      vec = '0;
    end
    return vec;
  endfunction

endpackage

// File: rtl/issue_scoreboard_wb_port_arb.sv
// Fixed-priority arbiter for the single register-file write port: ALU first, LSU second.
// Writes to x0 complete the handshake but never raise the write enable.
module wb_port_arb
  import issue_scoreboard_pkg::*;
(
  input  logic                 alu_wb_valid_i,
  input  logic [REG_IDX_W-1:0] alu_wb_idx_i,
  input  logic [XLEN-1:0]      alu_wb_data_i,
  input  logic                 lsu_wb_valid_i,
  output logic                 lsu_wb_ready_o,
  input  logic [REG_IDX_W-1:0] lsu_wb_idx_i,
  input  logic [XLEN-1:0]      lsu_wb_data_i,
  output logic                 rf_wen_o,
  output logic [REG_IDX_W-1:0] rf_widx_o,
  output logic [XLEN-1:0]      rf_wdata_o,
  output logic                 lsu_grant_o,
  output logic                 clr_valid_o,
  output logic [REG_IDX_W-1:0] clr_idx_o
);

  wb_src_e src_s;

  // Source select: the ALU cannot stall, so it always wins the port.
  always_comb begin
    src_s = WB_SRC_NONE;
    if (alu_wb_valid_i) begin
      src_s = WB_SRC_ALU;
    end else if (lsu_wb_valid_i) begin
      src_s = WB_SRC_LSU;
    end else begin
      src_s = WB_SRC_NONE;
    end
  end

  // Port mux; idle port drives zeros.
  always_comb begin
    rf_widx_o   = '0;
    rf_wdata_o  = '0;
    lsu_grant_o = 1'b0;
    case (src_s)
      WB_SRC_ALU: begin
        rf_widx_o  = alu_wb_idx_i;
        rf_wdata_o = alu_wb_data_i;
      end
      WB_SRC_LSU: begin
        rf_widx_o   = lsu_wb_idx_i;
        rf_wdata_o  = lsu_wb_data_i;
        lsu_grant_o = 1'b1;
      end
      default: begin
        rf_widx_o   = '0;
        rf_wdata_o  = '0;
        lsu_grant_o = 1'b0;
      end
    endcase
  end

  assign lsu_wb_ready_o = ~alu_wb_valid_i;
  assign rf_wen_o       = (src_s != WB_SRC_NONE) && (rf_widx_o != '0);
  assign clr_valid_o    = rf_wen_o;
  assign clr_idx_o      = rf_widx_o;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller: busy-register scoreboard with RAW/WAW stall, LSU outstanding limit,
// a single valid/ready issue slot, and the shared register-file write port.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NREGS         = 32,
  parameter int LSU_MAX_OUTST = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  logic [REG_IDX_W-1:0] dec_rs1_idx_i,
  input  logic [REG_IDX_W-1:0] dec_rs2_idx_i,
  input  logic [REG_IDX_W-1:0] dec_rd_idx_i,
  input  logic                 dec_rs1_en_i,
  input  logic                 dec_rs2_en_i,
  input  logic                 dec_rd_en_i,
  input  logic                 dec_lsu_i,
  output logic                 iss_valid_o,
  input  logic                 iss_ready_i,
  output logic [REG_IDX_W-1:0] iss_rs1_idx_o,
  output logic [REG_IDX_W-1:0] iss_rs2_idx_o,
  output logic [REG_IDX_W-1:0] iss_rd_idx_o,
  output logic                 iss_rd_en_o,
  output logic                 iss_lsu_o,
  input  logic                 alu_wb_valid_i,
  input  logic [REG_IDX_W-1:0] alu_wb_idx_i,
  input  logic [XLEN-1:0]      alu_wb_data_i,
  input  logic                 lsu_wb_valid_i,
  output logic                 lsu_wb_ready_o,
  input  logic [REG_IDX_W-1:0] lsu_wb_idx_i,
  input  logic [XLEN-1:0]      lsu_wb_data_i,
  output logic                 rf_wen_o,
  output logic [REG_IDX_W-1:0] rf_widx_o,
  output logic [XLEN-1:0]      rf_wdata_o,
  output logic                 sb_err_o
);

  logic [NREGS-1:0]     busy_r;
  logic [NREGS-1:0]     busy_set_s;
  logic [NREGS-1:0]     busy_clr_s;
  logic [NREGS-1:0]     busy_nxt_s;
  logic [LSU_CNT_W-1:0] lsu_cnt_r;
  logic [LSU_CNT_W-1:0] lsu_cnt_nxt_s;
  iss_slot_t            slot_r;
  logic                 iss_valid_r;
  logic                 sb_err_r;
  logic                 raw_s;
  logic                 waw_s;
  logic                 lsu_full_s;
  logic                 slot_free_s;
  logic                 accept_s;
  logic                 err_hit_s;
  logic                 lsu_grant_s;
  logic                 clr_valid_s;
  logic [REG_IDX_W-1:0] clr_idx_s;

  wb_port_arb u_wb_port_arb (
    .alu_wb_valid_i (alu_wb_valid_i),
    .alu_wb_idx_i   (alu_wb_idx_i),
    .alu_wb_data_i  (alu_wb_data_i),
    .lsu_wb_valid_i (lsu_wb_valid_i),
    .lsu_wb_ready_o (lsu_wb_ready_o),
    .lsu_wb_idx_i   (lsu_wb_idx_i),
    .lsu_wb_data_i  (lsu_wb_data_i),
    .rf_wen_o       (rf_wen_o),
    .rf_widx_o      (rf_widx_o),
    .rf_wdata_o     (rf_wdata_o),
    .lsu_grant_o    (lsu_grant_s),
    .clr_valid_o    (clr_valid_s),
    .clr_idx_o      (clr_idx_s)
  );

  // Hazard terms read only registered state; no same-cycle wakeup from writeback.
  always_comb begin
    raw_s       = (dec_rs1_en_i & busy_r[dec_rs1_idx_i]) |
                  (dec_rs2_en_i & busy_r[dec_rs2_idx_i]);
    waw_s       = dec_rd_en_i & busy_r[dec_rd_idx_i];
    lsu_full_s  = dec_lsu_i & (lsu_cnt_r == LSU_CNT_W'(LSU_MAX_OUTST));
    slot_free_s = ~iss_valid_r | iss_ready_i;
  end

  assign dec_ready_o = ~raw_s & ~waw_s & ~lsu_full_s & slot_free_s;
  assign accept_s    = dec_valid_i & dec_ready_o;

  // Busy update: clear on granted writeback, set on accept; set wins on collision.
  always_comb begin
    busy_set_s = idx_decode(dec_rd_idx_i, accept_s & dec_rd_en_i);
    busy_clr_s = idx_decode(clr_idx_s, clr_valid_s);
    busy_nxt_s = (busy_r & ~busy_clr_s) | busy_set_s;
    err_hit_s  = clr_valid_s & ~busy_r[clr_idx_s];
  end

  // Outstanding-LSU count; floors at zero so a stray LSU writeback cannot wrap it.
  always_comb begin
    lsu_cnt_nxt_s = lsu_cnt_r;
    case ({accept_s & dec_lsu_i, lsu_grant_s})
      2'b10: begin
        lsu_cnt_nxt_s = lsu_cnt_r + LSU_CNT_W'(1'b1);
      end
      2'b01: begin
        if (lsu_cnt_r != '0) begin
          lsu_cnt_nxt_s = lsu_cnt_r - LSU_CNT_W'(1'b1);
        end else begin
          lsu_cnt_nxt_s = lsu_cnt_r;
        end
      end
      default: begin
        lsu_cnt_nxt_s = lsu_cnt_r;
      end
    endcase
  end

  // Scoreboard state and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r    <= '0;
      lsu_cnt_r <= '0;
      sb_err_r  <= 1'b0;
    end else begin
      busy_r    <= {busy_nxt_s[NREGS-1:1], 1'b0};
      lsu_cnt_r <= lsu_cnt_nxt_s;
      sb_err_r  <= sb_err_r | err_hit_s;
    end
  end

  // Issue slot: load on accept (no bubble when consumed the same cycle), drop on consume, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_valid_r <= 1'b0;
      slot_r      <= '0;
    end else if (accept_s) begin
      iss_valid_r    <= 1'b1;
      slot_r.rs1_idx <= dec_rs1_idx_i;
      slot_r.rs2_idx <= dec_rs2_idx_i;
      slot_r.rd_idx  <= dec_rd_idx_i;
      slot_r.rd_en   <= dec_rd_en_i;
      slot_r.lsu     <= dec_lsu_i;
    end else if (iss_ready_i) begin
      iss_valid_r <= 1'b0;
    end else begin
      iss_valid_r <= iss_valid_r;
    end
  end

  assign iss_valid_o   = iss_valid_r;
  assign iss_rs1_idx_o = slot_r.rs1_idx;
  assign iss_rs2_idx_o = slot_r.rs2_idx;
  assign iss_rd_idx_o  = slot_r.rd_idx;
  assign iss_rd_en_o   = slot_r.rd_en;
  assign iss_lsu_o     = slot_r.lsu;
  assign sb_err_o      = sb_err_r;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios followed by random traffic, all
// checked every cycle against a rule-level model (busy table, LSU count, pending queues).
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam int NREGS   = 32;
  localparam int LSU_MAX = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 dec_valid_i, dec_ready_o;
  logic [REG_IDX_W-1:0] dec_rs1_idx_i, dec_rs2_idx_i, dec_rd_idx_i;
  logic                 dec_rs1_en_i, dec_rs2_en_i, dec_rd_en_i, dec_lsu_i;
  logic                 iss_valid_o, iss_ready_i;
  logic [REG_IDX_W-1:0] iss_rs1_idx_o, iss_rs2_idx_o, iss_rd_idx_o;
  logic                 iss_rd_en_o, iss_lsu_o;
  logic                 alu_wb_valid_i;
  logic [REG_IDX_W-1:0] alu_wb_idx_i;
  logic [XLEN-1:0]      alu_wb_data_i;
  logic                 lsu_wb_valid_i, lsu_wb_ready_o;
  logic [REG_IDX_W-1:0] lsu_wb_idx_i;
  logic [XLEN-1:0]      lsu_wb_data_i;
  logic                 rf_wen_o;
  logic [REG_IDX_W-1:0] rf_widx_o;
  logic [XLEN-1:0]      rf_wdata_o;
  logic                 sb_err_o;

  issue_scoreboard #(.NREGS(NREGS), .LSU_MAX_OUTST(LSU_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_rs1_idx_i(dec_rs1_idx_i), .dec_rs2_idx_i(dec_rs2_idx_i), .dec_rd_idx_i(dec_rd_idx_i),
    .dec_rs1_en_i(dec_rs1_en_i), .dec_rs2_en_i(dec_rs2_en_i), .dec_rd_en_i(dec_rd_en_i),
    .dec_lsu_i(dec_lsu_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
    .iss_rs1_idx_o(iss_rs1_idx_o), .iss_rs2_idx_o(iss_rs2_idx_o), .iss_rd_idx_o(iss_rd_idx_o),
    .iss_rd_en_o(iss_rd_en_o), .iss_lsu_o(iss_lsu_o),
    .alu_wb_valid_i(alu_wb_valid_i), .alu_wb_idx_i(alu_wb_idx_i), .alu_wb_data_i(alu_wb_data_i),
    .lsu_wb_valid_i(lsu_wb_valid_i), .lsu_wb_ready_o(lsu_wb_ready_o),
    .lsu_wb_idx_i(lsu_wb_idx_i), .lsu_wb_data_i(lsu_wb_data_i),
    .rf_wen_o(rf_wen_o), .rf_widx_o(rf_widx_o), .rf_wdata_o(rf_wdata_o),
    .sb_err_o(sb_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state.
  bit                   m_busy [NREGS];
  int                   m_cnt;
  bit                   m_sv, m_rden, m_lsu, m_err;
  logic [REG_IDX_W-1:0] m_rs1, m_rs2, m_rd;
  int                   alu_pend[$];
  int                   lsu_pend[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_cnt = 0; m_sv = 0; m_rden = 0; m_lsu = 0; m_err = 0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    alu_pend.delete();
    lsu_pend.delete();
  endtask

  task automatic idle();
    dec_valid_i = 1'b0; dec_rs1_idx_i = '0; dec_rs2_idx_i = '0; dec_rd_idx_i = '0;
    dec_rs1_en_i = 1'b0; dec_rs2_en_i = 1'b0; dec_rd_en_i = 1'b0; dec_lsu_i = 1'b0;
    iss_ready_i = 1'b1;
    alu_wb_valid_i = 1'b0; alu_wb_idx_i = '0; alu_wb_data_i = '0;
    lsu_wb_valid_i = 1'b0; lsu_wb_idx_i = '0; lsu_wb_data_i = '0;
  endtask

  task automatic set_dec(input bit v, input int rs1, input int rs2, input int rd,
                         input bit e1, input bit e2, input bit ed, input bit lsu);
    dec_valid_i = v; dec_rs1_idx_i = REG_IDX_W'(rs1); dec_rs2_idx_i = REG_IDX_W'(rs2);
    dec_rd_idx_i = REG_IDX_W'(rd); dec_rs1_en_i = e1; dec_rs2_en_i = e2;
    dec_rd_en_i = ed; dec_lsu_i = lsu;
  endtask

  // Compare every output against the model for the current inputs, then advance one clock.
  task automatic tick();
    bit raw, waw, full, exp_ready, acc, alu_g, lsu_g, wr;
    int gidx;
    logic [XLEN-1:0] gdata;
    #1;
    raw  = (dec_rs1_en_i && m_busy[dec_rs1_idx_i]) || (dec_rs2_en_i && m_busy[dec_rs2_idx_i]);
    waw  = dec_rd_en_i && m_busy[dec_rd_idx_i];
    full = dec_lsu_i && (m_cnt == LSU_MAX);
    exp_ready = !raw && !waw && !full && (!m_sv || iss_ready_i);
    alu_g = alu_wb_valid_i;
    lsu_g = !alu_wb_valid_i && lsu_wb_valid_i;
    gidx = 0;
    gdata = '0;
    if (alu_g) begin
      gidx = int'(alu_wb_idx_i); gdata = alu_wb_data_i;
    end else if (lsu_g) begin
      gidx = int'(lsu_wb_idx_i); gdata = lsu_wb_data_i;
    end
    wr = (alu_g || lsu_g) && (gidx != 0);

    check_eq("dec_ready", dec_ready_o, exp_ready);
    check_eq("lsu_wb_ready", lsu_wb_ready_o, !alu_wb_valid_i);
    check_eq("rf_wen", rf_wen_o, wr);
    check_eq("rf_widx", rf_widx_o, gidx);
    check_eq("rf_wdata", rf_wdata_o, gdata);
    check_eq("iss_valid", iss_valid_o, m_sv);
    check_eq("iss_rs1", iss_rs1_idx_o, m_rs1);
    check_eq("iss_rs2", iss_rs2_idx_o, m_rs2);
    check_eq("iss_rd", iss_rd_idx_o, m_rd);
    check_eq("iss_rd_en", iss_rd_en_o, m_rden);
    check_eq("iss_lsu", iss_lsu_o, m_lsu);
    check_eq("sb_err", sb_err_o, m_err);

    acc = dec_valid_i && exp_ready;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (wr) begin
        if (!m_busy[gidx]) m_err = 1'b1;
        m_busy[gidx] = 1'b0;
      end
      if (acc && dec_rd_en_i && dec_rd_idx_i != '0) m_busy[dec_rd_idx_i] = 1'b1;
      if (acc && dec_lsu_i) m_cnt++;
      if (lsu_g) m_cnt--;
      if (alu_g) begin
        for (int i = 0; i < alu_pend.size(); i++) begin
          if (alu_pend[i] == gidx) begin
            alu_pend.delete(i);
            break;
          end
        end
      end
      if (lsu_g && lsu_pend.size() > 0) void'(lsu_pend.pop_front());
      if (acc) begin
        if (dec_lsu_i) lsu_pend.push_back(dec_rd_en_i ? int'(dec_rd_idx_i) : 0);
        else if (dec_rd_en_i && dec_rd_idx_i != '0) alu_pend.push_back(int'(dec_rd_idx_i));
        m_sv = 1'b1; m_rs1 = dec_rs1_idx_i; m_rs2 = dec_rs2_idx_i; m_rd = dec_rd_idx_i;
        m_rden = dec_rd_en_i; m_lsu = dec_lsu_i;
      end else if (iss_ready_i) begin
        m_sv = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    model_reset();

    // Reset state.
    #1;
    check_eq("rst_iss_valid", iss_valid_o, 64'd0);
    check_eq("rst_sb_err", sb_err_o, 64'd0);
    check_eq("rst_iss_rd", iss_rd_idx_o, 64'd0);
    tick();

    // 1: ADD rd=5 accepted, lands in the slot.
    rst_n = 1'b1;
    set_dec(1, 1, 2, 5, 1, 1, 1, 0); iss_ready_i = 1'b0;
    #1 check_eq("t1_ready", dec_ready_o, 64'd1);
    tick();
    idle(); iss_ready_i = 1'b1;
    #1 check_eq("t1_iss_valid", iss_valid_o, 64'd1);
    check_eq("t1_iss_rd", iss_rd_idx_o, 64'd5);

    // 2: RAW on x5, released one cycle after ALU writeback.
    set_dec(1, 5, 0, 6, 1, 0, 1, 0);
    #1 check_eq("t2_raw_stall", dec_ready_o, 64'd0);
    tick();
    alu_wb_valid_i = 1'b1; alu_wb_idx_i = 5'd5; alu_wb_data_i = 32'h0000_0055;
    #1 check_eq("t2_wb_wen", rf_wen_o, 64'd1);
    check_eq("t2_wb_idx", rf_widx_o, 64'd5);
    check_eq("t2_no_bypass", dec_ready_o, 64'd0);
    tick();
    alu_wb_valid_i = 1'b0;
    #1 check_eq("t2_wakeup", dec_ready_o, 64'd1);
    tick();

    // 3: ALU and LSU collide on the write port.
    set_dec(1, 0, 0, 3, 0, 0, 1, 0); tick();
    set_dec(1, 0, 0, 7, 0, 0, 1, 1); tick();
    idle();
    alu_wb_valid_i = 1'b1; alu_wb_idx_i = 5'd3; alu_wb_data_i = 32'hA3A3_0003;
    lsu_wb_valid_i = 1'b1; lsu_wb_idx_i = 5'd7; lsu_wb_data_i = 32'h5757_0007;
    #1 check_eq("t3_alu_idx", rf_widx_o, 64'd3);
    check_eq("t3_alu_data", rf_wdata_o, 64'hA3A3_0003);
    check_eq("t3_lsu_blocked", lsu_wb_ready_o, 64'd0);
    tick();
    alu_wb_valid_i = 1'b0;
    #1 check_eq("t3_lsu_idx", rf_widx_o, 64'd7);
    check_eq("t3_lsu_ready", lsu_wb_ready_o, 64'd1);
    tick();
    idle();

    // 4: LSU outstanding limit.
    set_dec(1, 0, 0, 8, 0, 0, 1, 1); tick();
    set_dec(1, 0, 0, 9, 0, 0, 1, 1); tick();
    set_dec(1, 0, 0, 10, 0, 0, 1, 1);
    #1 check_eq("t4_full", dec_ready_o, 64'd0);
    tick();
    lsu_wb_valid_i = 1'b1; lsu_wb_idx_i = 5'd8; lsu_wb_data_i = 32'h0000_0808;
    #1 check_eq("t4_full_same_cycle", dec_ready_o, 64'd0);
    tick();
    lsu_wb_valid_i = 1'b0;
    #1 check_eq("t4_room", dec_ready_o, 64'd1);
    tick();
    idle();
    lsu_wb_valid_i = 1'b1; lsu_wb_idx_i = 5'd9; tick();
    lsu_wb_idx_i = 5'd10; tick();
    idle();
    alu_wb_valid_i = 1'b1; alu_wb_idx_i = 5'd6; tick();
    idle();

    // 5: x0 handling and sticky error.
    set_dec(1, 0, 0, 0, 0, 0, 1, 0); tick();
    idle();
    alu_wb_valid_i = 1'b1; alu_wb_idx_i = 5'd0; alu_wb_data_i = 32'hDEAD_0000;
    #1 check_eq("t5_x0_wen", rf_wen_o, 64'd0);
    tick();
    alu_wb_idx_i = 5'd12; alu_wb_data_i = 32'h0000_0C0C;
    #1 check_eq("t5_x0_no_err", sb_err_o, 64'd0);
    tick();
    idle();
    #1 check_eq("t5_err_set", sb_err_o, 64'd1);
    repeat (3) tick();
    check_eq("t5_err_sticky", sb_err_o, 64'd1);

    // 6: back-pressure, then reset during the stall.
    set_dec(1, 0, 0, 13, 0, 0, 1, 0); iss_ready_i = 1'b0; tick();
    set_dec(1, 3, 4, 14, 1, 1, 1, 0); iss_ready_i = 1'b0;
    #1 check_eq("t6_bp_stall", dec_ready_o, 64'd0);
    check_eq("t6_hold_a", iss_rd_idx_o, 64'd13);
    tick();
    check_eq("t6_hold_b", iss_rd_idx_o, 64'd13);
    check_eq("t6_hold_valid", iss_valid_o, 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    #1 check_eq("t6_rst_valid", iss_valid_o, 64'd0);
    check_eq("t6_rst_rd", iss_rd_idx_o, 64'd0);
    check_eq("t6_rst_err", sb_err_o, 64'd0);

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      rst_n = (cyc % 997 == 996) ? 1'b0 : 1'b1;
      set_dec(($urandom % 100) < 70, $urandom % 12, $urandom % 12, $urandom % 12,
              ($urandom % 100) < 70, ($urandom % 100) < 70, ($urandom % 100) < 85,
              ($urandom % 100) < 30);
      iss_ready_i = ($urandom % 100) < 60;
      alu_wb_data_i = $urandom;
      lsu_wb_data_i = $urandom;
      if (alu_pend.size() > 0 && ($urandom % 100) < 35) begin
        alu_wb_valid_i = 1'b1;
        alu_wb_idx_i = REG_IDX_W'(alu_pend[$urandom % alu_pend.size()]);
      end else if (($urandom % 100) < 3) begin
        alu_wb_valid_i = 1'b1;
        alu_wb_idx_i = '0;
      end
      if (lsu_pend.size() > 0 && ($urandom % 100) < 50) begin
        lsu_wb_valid_i = 1'b1;
        lsu_wb_idx_i = REG_IDX_W'(lsu_pend[0]);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
